// File: rtl/img_window_gen.sv
`default_nettype none
// ============================================================================
// img_window_gen : buffers a 28x28 8-bit frame, then sweeps every 5x5 window
//                  (Y fastest) one per clock for the simpleCNN stage.
// Revision       : 1.0
// ============================================================================
module img_window_gen #(
    parameter int IMG_DIM = 28,
    parameter int KSIZE   = 5
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         PIX_VALID,
    input  logic [7:0]   PIX_DATA,
    output logic         PIX_READY,
    output logic         START,
    output logic [4:0]   X,
    output logic [4:0]   Y,
    output logic [199:0] IMGIN,
    output logic         WIN_VALID,
    output logic         FRAME_DONE
);
    localparam int         OUT_DIM    = IMG_DIM - KSIZE + 1;
    localparam int         NPIX       = IMG_DIM * IMG_DIM;
    localparam logic [9:0] LAST_PIX   = 10'(NPIX - 1);
    localparam logic [4:0] LAST_POS   = 5'(OUT_DIM - 1);
    localparam logic [9:0] ROW_STRIDE = 10'(IMG_DIM);

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        KICK  = 2'd1,
        SWEEP = 2'd2
    } state_t;

    state_t       state;
    state_t       state_next;
    logic [9:0]   cnt;
    logic [7:0]   mem [0:NPIX-1];
    logic         accept;
    logic         sweep_last;
    logic [4:0]   nx;
    logic [4:0]   ny;
    logic [9:0]   base;
    logic [9:0]   addr;
    logic [199:0] win_next;

    assign PIX_READY  = (state == LOAD);
    assign accept     = PIX_VALID && (state == LOAD);
    assign sweep_last = (state == SWEEP) && (X == LAST_POS) && (Y == LAST_POS);

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state <= LOAD;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            LOAD:    if (accept && cnt == LAST_PIX) state_next = KICK;
            KICK:    state_next = SWEEP;
            SWEEP:   if (sweep_last) state_next = LOAD;
            default: state_next = LOAD;
        endcase
    end

    // Origin of the window loaded on the coming edge; (0,0) outside SWEEP and
    // after the final window so the mux never addresses past the frame.
    always_comb begin
        nx = '0;
        ny = '0;
        if (state == SWEEP && !sweep_last) begin
            if (Y == LAST_POS) begin
                nx = X + 5'd1;
            end else begin
                nx = X;
                ny = Y + 5'd1;
            end
        end
    end

    always_comb begin
        win_next = '0;
        addr     = '0;
        base     = {5'd0, nx} * ROW_STRIDE + {5'd0, ny};
        for (int i = 0; i < KSIZE; i++) begin
            for (int j = 0; j < KSIZE; j++) begin
                addr = base + 10'(i * IMG_DIM + j);
                win_next[(i*KSIZE+j)*8 +: 8] = mem[addr];
            end
        end
    end

    // Frame storage carries no reset; a new frame fully overwrites it.
    always_ff @(posedge CLK) begin
        if (nRST && accept) begin
            mem[cnt] <= PIX_DATA;
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            cnt        <= '0;
            START      <= 1'b0;
            WIN_VALID  <= 1'b0;
            FRAME_DONE <= 1'b0;
            X          <= '0;
            Y          <= '0;
            IMGIN      <= '0;
        end else begin
            START      <= 1'b0;
            FRAME_DONE <= 1'b0;
            case (state)
                LOAD: begin
                    if (accept) begin
                        if (cnt == LAST_PIX) begin
                            cnt   <= '0;
                            START <= 1'b1;
                        end else begin
                            cnt <= cnt + 10'd1;
                        end
                    end
                end
                KICK: begin
                    WIN_VALID <= 1'b1;
                    X         <= nx;
                    Y         <= ny;
                    IMGIN     <= win_next;
                end
                SWEEP: begin
                    if (sweep_last) begin
                        WIN_VALID  <= 1'b0;
                        FRAME_DONE <= 1'b1;
                        X          <= '0;
                        Y          <= '0;
                    end else begin
                        X     <= nx;
                        Y     <= ny;
                        IMGIN <= win_next;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule
`default_nettype wire

// File: tb/tb_img_window_gen.sv
`default_nettype none
// ============================================================================
// tb_img_window_gen : scoreboard bench for img_window_gen.
// Revision          : 1.0
// ============================================================================
module tb_img_window_gen;
    localparam int NPIX = 784;

    logic         CLK = 1'b0;
    logic         nRST;
    logic         PIX_VALID;
    logic [7:0]   PIX_DATA;
    logic         PIX_READY;
    logic         START;
    logic [4:0]   X;
    logic [4:0]   Y;
    logic [199:0] IMGIN;
    logic         WIN_VALID;
    logic         FRAME_DONE;

    img_window_gen dut (
        .CLK        (CLK),
        .nRST       (nRST),
        .PIX_VALID  (PIX_VALID),
        .PIX_DATA   (PIX_DATA),
        .PIX_READY  (PIX_READY),
        .START      (START),
        .X          (X),
        .Y          (Y),
        .IMGIN      (IMGIN),
        .WIN_VALID  (WIN_VALID),
        .FRAME_DONE (FRAME_DONE)
    );

    always #5 CLK = ~CLK;

    int cyc = 0;
    always @(posedge CLK) cyc++;

    int           n_cmp   = 0;
    int           n_err   = 0;
    int           win_cnt = 0;
    logic [209:0] sb_q[$];
    logic [209:0] exp_w;

    task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // kind 0: ramp, 1: inverted ramp, 2: all 0x01
    function automatic logic [7:0] pix(input int kind, input int p);
        case (kind)
            0:       return 8'(p % 256);
            1:       return 8'(255 - (p % 256));
            default: return 8'h01;
        endcase
    endfunction

    function automatic logic [199:0] win(input int kind, input int x, input int y);
        logic [199:0] w;
        w = '0;
        for (int i = 0; i < 5; i++)
            for (int j = 0; j < 5; j++)
                w[(i*5+j)*8 +: 8] = pix(kind, (x + i) * 28 + y + j);
        return w;
    endfunction

    task automatic push_windows(input int kind);
        for (int x = 0; x < 24; x++)
            for (int y = 0; y < 24; y++)
                sb_q.push_back({5'(x), 5'(y), win(kind, x, y)});
    endtask

    always @(negedge CLK) begin
        if (WIN_VALID === 1'b1) begin
            win_cnt++;
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL window_unexpected: got X=%0d Y=%0d, expected no window", X, Y);
            end else begin
                exp_w = sb_q.pop_front();
                chk("window", {46'd0, X, Y, IMGIN}, {46'd0, exp_w});
            end
        end
    end

    task automatic check_reset_state(input string tag);
        chk({tag, "_start"},      START,      0);
        chk({tag, "_win_valid"},  WIN_VALID,  0);
        chk({tag, "_frame_done"}, FRAME_DONE, 0);
        chk({tag, "_x"},          X,          0);
        chk({tag, "_y"},          Y,          0);
        chk({tag, "_imgin"},      IMGIN,      0);
        chk({tag, "_pix_ready"},  PIX_READY,  1);
    endtask

    // Called just after an edge; returns the cycle numbers of first/last accept.
    task automatic load_frame(input int kind, input bit sparse, input int stop_at,
                              output int first_acc, output int last_acc);
        int p;
        int guard;
        int early;
        bit rdy;
        p = 0; guard = 0; early = 0; first_acc = -1; last_acc = -1;
        while (p < stop_at && guard < 5000) begin
            rdy       = PIX_READY;
            if (START) early++;
            PIX_VALID = sparse ? 1'($urandom_range(0, 1)) : 1'b1;
            PIX_DATA  = pix(kind, p);
            @(posedge CLK); #1;
            guard++;
            if (PIX_VALID && rdy) begin
                if (p == 0) first_acc = cyc;
                last_acc = cyc;
                p++;
            end
        end
        chk("load_no_early_start", early, 0);
        chk("load_pixels_accepted", p, stop_at);
    endtask

    task automatic sweep_check(input int kind, input int e);
        int guard;
        int ready_bad;
        win_cnt = 0;
        chk("start_high", START, 1);
        PIX_VALID = 1'b1;
        PIX_DATA  = 8'hFF;
        @(posedge CLK); #1;
        chk("start_one_cycle", START, 0);
        chk("win_valid_first", WIN_VALID, 1);
        chk("first_xy", {X, Y}, 10'd0);
        if (kind == 0) begin
            chk("w00_bytes0_4", IMGIN[39:0], 40'h04_03_02_01_00);
            chk("w00_byte5", IMGIN[47:40], 8'd28);
            chk("w00_byte24", IMGIN[199:192], 8'd116);
        end
        guard = 0; ready_bad = 0;
        while (FRAME_DONE !== 1'b1 && guard < 700) begin
            if (PIX_READY !== 1'b0) ready_bad++;
            if (kind == 0 && cyc == e + 576) begin
                chk("w2323_byte0", IMGIN[7:0], 8'd155);
                chk("w2323_byte24", IMGIN[199:192], 8'd15);
            end
            @(posedge CLK); #1;
            guard++;
        end
        PIX_VALID = 1'b0;
        chk("frame_done_time", cyc, e + 577);
        chk("ready_low_in_sweep", ready_bad, 0);
        chk("ready_at_done", PIX_READY, 1);
        chk("win_valid_at_done", WIN_VALID, 0);
        chk("window_count", win_cnt, 576);
        chk("scoreboard_drained", sb_q.size(), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int fa;
        int e;
        int e2;
        int fd_seen;
        nRST = 1'b0; PIX_VALID = 1'b0; PIX_DATA = 8'h00;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_state("init");
        nRST = 1'b1;

        // Ramp frame, valid always high, 0xFF offered during sweep
        load_frame(0, 1'b0, NPIX, fa, e);
        push_windows(0);
        sweep_check(0, e);
        @(posedge CLK); #1;
        chk("frame_done_clears", FRAME_DONE, 0);

        // Sparse load of the same ramp
        load_frame(0, 1'b1, NPIX, fa, e);
        push_windows(0);
        sweep_check(0, e);

        // Reset in the middle of a sweep: no FRAME_DONE afterwards
        load_frame(1, 1'b0, NPIX, fa, e);
        push_windows(1);
        PIX_VALID = 1'b1; PIX_DATA = 8'hFF;
        repeat (100) @(posedge CLK);
        #1;
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        sb_q.delete();
        check_reset_state("rst_sweep");
        nRST = 1'b1; PIX_VALID = 1'b0;
        fd_seen = 0;
        repeat (4) begin
            @(posedge CLK); #1;
            if (FRAME_DONE !== 1'b0 || WIN_VALID !== 1'b0) fd_seen++;
        end
        chk("no_done_after_abort", fd_seen, 0);

        // Reset at pixel 400 with a pixel offered, then a full all-0x01 frame
        load_frame(2, 1'b0, 400, fa, e);
        nRST = 1'b0;
        repeat (2) @(posedge CLK);
        #1;
        check_reset_state("rst_load");
        nRST = 1'b1;
        load_frame(2, 1'b0, NPIX, fa, e);
        push_windows(2);
        sweep_check(2, e);

        // Back-to-back frames A (ramp) and B (inverted ramp)
        load_frame(0, 1'b0, NPIX, fa, e);
        push_windows(0);
        sweep_check(0, e);
        load_frame(1, 1'b0, NPIX, fa, e2);
        chk("b2b_first_accept", fa, e + 578);
        push_windows(1);
        sweep_check(1, e2);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
`default_nettype wire
